// File: rtl/pwm_duty_cap.sv
// pwm_duty_cap: watches a PWM/DIR pair from the motor driver, measures the PWM
// high time per frame and rebuilds the signed 12-bit duty word.
// Optional build macro PWM_SYNC_EN: adds a 2-flop synchronizer on PWM and DIR.
module pwm_duty_cap #(
    parameter int unsigned PERIOD = 2048,
    parameter int unsigned CNT_W  = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PWM,
    input  logic        DIR,
    output logic [11:0] duty,
    output logic        vld,
    output logic        sat,
    output logic        per_err
);

    localparam int unsigned MagW = 11;

    localparam logic [CNT_W-1:0] PeriodC  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] PeriodM1 = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StHigh  = 2'd1;
    localparam logic [1:0] StLow   = 2'd2;
    localparam logic [1:0] StStuck = 2'd3;

    logic pwm_s;
    logic dir_s;
    logic pwm_q;
    logic rise;
    logic fall;

`ifdef PWM_SYNC_EN
    logic [1:0] pwm_sync_q;
    logic [1:0] dir_sync_q;

    // Two-flop synchronizers for an asynchronous PWM/DIR source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_sync_q <= 2'b00;
            dir_sync_q <= 2'b00;
        end else begin
            pwm_sync_q <= {pwm_sync_q[0], PWM};
            dir_sync_q <= {dir_sync_q[0], DIR};
        end
    end

    assign pwm_s = pwm_sync_q[1];
    assign dir_s = dir_sync_q[1];
`else
    assign pwm_s = PWM;
    assign dir_s = DIR;
`endif

    // One-cycle delayed PWM for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= pwm_s;
        end
    end

    assign rise = pwm_s & ~pwm_q;
    assign fall = ~pwm_s & pwm_q;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic             per_vld_q, per_vld_d;
    logic             emit;
    logic             emit_sat;
    logic [MagW-1:0]  emit_mag;
    logic             per_err_d;
    logic [11:0]      duty_q, duty_d;
    logic             vld_q;
    logic             sat_q;
    logic             per_err_q;

    // Frame measurement FSM: decides when to emit and what magnitude to report.
    always_comb begin
        state_d    = state_q;
        high_cnt_d = high_cnt_q;
        low_cnt_d  = low_cnt_q;
        per_cnt_d  = per_cnt_q;
        per_vld_d  = per_vld_q;
        emit       = 1'b0;
        emit_sat   = 1'b0;
        emit_mag   = '0;
        per_err_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (rise) begin
                    // First rise after idle: start a frame, nothing to compare against.
                    state_d    = StHigh;
                    high_cnt_d = CNT_W'(1);
                    per_cnt_d  = CNT_W'(1);
                    per_vld_d  = 1'b1;
                    low_cnt_d  = '0;
                end else if (low_cnt_q == PeriodM1) begin
                    emit      = 1'b1;
                    low_cnt_d = '0;
                end else begin
                    low_cnt_d = low_cnt_q + 1'b1;
                end
            end
            StHigh: begin
                // Period counter runs through the falling-edge cycle too.
                per_cnt_d = (per_cnt_q == CntMax) ? per_cnt_q : per_cnt_q + 1'b1;
                if (fall) begin
                    emit      = 1'b1;
                    emit_mag  = high_cnt_q[MagW-1:0];
                    low_cnt_d = '0;
                    state_d   = StLow;
                end else if (high_cnt_q == PeriodM1) begin
                    // This cycle completes a full PERIOD high: PWM is stuck.
                    emit       = 1'b1;
                    emit_sat   = 1'b1;
                    emit_mag   = '1;
                    high_cnt_d = '0;
                    per_vld_d  = 1'b0;
                    state_d    = StStuck;
                end else begin
                    high_cnt_d = high_cnt_q + 1'b1;
                end
            end
            StStuck: begin
                if (fall) begin
                    low_cnt_d = '0;
                    state_d   = StLow;
                end else if (high_cnt_q == PeriodM1) begin
                    emit       = 1'b1;
                    emit_sat   = 1'b1;
                    emit_mag   = '1;
                    high_cnt_d = '0;
                end else begin
                    high_cnt_d = high_cnt_q + 1'b1;
                end
            end
            StLow: begin
                if (rise) begin
                    if (per_vld_q && (per_cnt_q != PeriodC)) begin
                        per_err_d = 1'b1;
                    end
                    per_cnt_d  = CNT_W'(1);
                    high_cnt_d = CNT_W'(1);
                    per_vld_d  = 1'b1;
                    state_d    = StHigh;
                end else if (low_cnt_q == PeriodM1) begin
                    // No rise for a whole frame: duty 0, drop back to idle.
                    emit      = 1'b1;
                    low_cnt_d = '0;
                    per_vld_d = 1'b0;
                    state_d   = StIdle;
                end else begin
                    low_cnt_d = low_cnt_q + 1'b1;
                    per_cnt_d = (per_cnt_q == CntMax) ? per_cnt_q : per_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Signed duty from magnitude; negative direction uses the one's complement form.
    always_comb begin
        duty_d = duty_q;
        if (emit) begin
            duty_d = dir_s ? {1'b1, ~emit_mag} : {1'b0, emit_mag};
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            high_cnt_q <= '0;
            low_cnt_q  <= '0;
            per_cnt_q  <= '0;
            per_vld_q  <= 1'b0;
            duty_q     <= 12'h000;
            vld_q      <= 1'b0;
            sat_q      <= 1'b0;
            per_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            high_cnt_q <= high_cnt_d;
            low_cnt_q  <= low_cnt_d;
            per_cnt_q  <= per_cnt_d;
            per_vld_q  <= per_vld_d;
            duty_q     <= duty_d;
            vld_q      <= emit;
            sat_q      <= emit_sat;
            per_err_q  <= per_err_d;
        end
    end

    assign duty    = duty_q;
    assign vld     = vld_q;
    assign sat     = sat_q;
    assign per_err = per_err_q;

endmodule

// File: tb/tb_pwm_duty_cap.sv
// Testbench for pwm_duty_cap: scoreboard of expected (duty, sat, cycle) emits,
// popped whenever the DUT pulses vld.
module tb_pwm_duty_cap;

`ifdef PWM_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        PWM = 1'b0;
    logic        DIR = 1'b0;
    logic [11:0] duty;
    logic        vld;
    logic        sat;
    logic        per_err;

    typedef struct {
        logic [11:0] duty;
        logic        sat;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rel_cyc = 0;
    int   per_err_seen = 0;

    always #5 clk = ~clk;

    pwm_duty_cap #(
        .PERIOD(2048),
        .CNT_W (12)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .PWM    (PWM),
        .DIR    (DIR),
        .duty   (duty),
        .vld    (vld),
        .sat    (sat),
        .per_err(per_err)
    );

    // One clock: sample outputs on the falling edge, then step past the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_vld: no vld by cycle %0d, required duty=%h at cycle %0d",
                     cyc, e.duty, e.cyc);
        end
        if (vld) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_vld: got vld duty=%h sat=%b at cycle %0d, required none",
                         duty, sat, cyc);
            end else begin
                e = sb.pop_front();
                checks++;
                if (duty !== e.duty) begin
                    errors++;
                    $display("FAIL duty: got %h, required %h (cycle %0d)", duty, e.duty, cyc);
                end
                checks++;
                if (sat !== e.sat) begin
                    errors++;
                    $display("FAIL sat: got %b, required %b (cycle %0d)", sat, e.sat, cyc);
                end
                checks++;
                if (cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL vld_cycle: got %0d, required %0d", cyc, e.cyc);
                end
            end
        end else if (sat) begin
            checks++;
            errors++;
            $display("FAIL sat_without_vld: got sat=1 vld=0 at cycle %0d, required sat=0", cyc);
        end
        if (per_err) per_err_seen++;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset(input logic dir);
        rst_n = 1'b0;
        PWM   = 1'b0;
        DIR   = dir;
        ticks(3);
        rst_n   = 1'b1;
        rel_cyc = cyc;
    endtask

    // One PWM frame; the emit is expected one clock after the falling edge.
    task automatic frame(input int high, input int total, input logic dir,
                         input logic [11:0] exp_duty);
        DIR = dir;
        PWM = 1'b1;
        ticks(high);
        PWM = 1'b0;
        sb.push_back('{duty: exp_duty, sat: 1'b0, cyc: cyc + 1 + S});
        ticks(total - high);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: got %0d pending emits, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_per_err(input string name, input int base, input int exp_n);
        checks++;
        if (per_err_seen - base !== exp_n) begin
            errors++;
            $display("FAIL %s_per_err: got %0d pulses, required %0d",
                     name, per_err_seen - base, exp_n);
        end
    endtask

    task automatic test_reset();
        ticks(2);
        checks++;
        if (duty !== 12'h000) begin
            errors++;
            $display("FAIL reset_duty: got %h, required 000", duty);
        end
        checks++;
        if (vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_vld: got %b, required 0", vld);
        end
        checks++;
        if (sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_sat: got %b, required 0", sat);
        end
        checks++;
        if (per_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_per_err: got %b, required 0", per_err);
        end
    endtask

    task automatic test_duty_pos();
        int base;
        do_reset(1'b0);
        ticks(4);
        base = per_err_seen;
        repeat (3) frame(512, 2048, 1'b0, 12'h200);
        check_per_err("duty_pos", base, 0);
        check_drained("duty_pos");
    endtask

    task automatic test_duty_neg();
        do_reset(1'b1);
        ticks(4);
        repeat (2) frame(511, 2048, 1'b1, 12'hE00);
        check_drained("duty_neg");
    endtask

    task automatic test_idle_timeout();
        do_reset(1'b0);
        sb.push_back('{duty: 12'h000, sat: 1'b0, cyc: rel_cyc + 2048});
        sb.push_back('{duty: 12'h000, sat: 1'b0, cyc: rel_cyc + 4096});
        ticks(5000);
        check_drained("idle_pos");
        do_reset(1'b1);
        sb.push_back('{duty: 12'hFFF, sat: 1'b0, cyc: rel_cyc + 2048});
        sb.push_back('{duty: 12'hFFF, sat: 1'b0, cyc: rel_cyc + 4096});
        ticks(5000);
        check_drained("idle_neg");
    endtask

    task automatic test_stuck();
        int t;
        do_reset(1'b0);
        ticks(4);
        PWM = 1'b1;
        t   = cyc;
        sb.push_back('{duty: 12'h7FF, sat: 1'b1, cyc: t + 2048 + S});
        sb.push_back('{duty: 12'h7FF, sat: 1'b1, cyc: t + 4096 + S});
        ticks(4096);
        PWM = 1'b0;
        ticks(100);
        check_drained("stuck");
    endtask

    task automatic test_short_pulse();
        int f;
        do_reset(1'b0);
        ticks(4);
        PWM = 1'b1;
        ticks(1);
        PWM = 1'b0;
        f   = cyc;
        sb.push_back('{duty: 12'h001, sat: 1'b0, cyc: f + 1 + S});
        // LOW timeout after a whole frame with no rise.
        sb.push_back('{duty: 12'h000, sat: 1'b0, cyc: f + 2049 + S});
        ticks(2100);
        check_drained("short_pulse");
    endtask

    task automatic test_period_err();
        int base;
        do_reset(1'b0);
        ticks(4);
        base = per_err_seen;
        repeat (3) frame(100, 2000, 1'b0, 12'h064);
        check_per_err("period", base, 2);
        check_drained("period");
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset(1'b0);
        ticks(4);
        frame(512, 2048, 1'b0, 12'h200);
        PWM = 1'b1;
        ticks(300);
        rst_n = 1'b0;
        #1;
        checks++;
        if (duty !== 12'h000) begin
            errors++;
            $display("FAIL midreset_duty: got %h, required 000", duty);
        end
        checks++;
        if (vld !== 1'b0 || sat !== 1'b0 || per_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_flags: got vld=%b sat=%b per_err=%b, required 0 0 0",
                     vld, sat, per_err);
        end
        PWM = 1'b0;
        ticks(3);
        rst_n = 1'b1;
        base  = per_err_seen;
        ticks(4);
        repeat (2) frame(512, 2048, 1'b0, 12'h200);
        check_per_err("midreset", base, 0);
        check_drained("midreset");
    endtask

    initial begin
        test_reset();
        test_duty_pos();
        test_duty_neg();
        test_idle_timeout();
        test_stuck();
        test_short_pulse();
        test_period_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
